// File: rtl/MD_pkg.sv
// Shared types for the MD position cache: offset containers, cache FSM states
// and the default bank depth.
package MD_pkg;

    localparam int POS_CACHE_DEPTH    = 256;
    localparam int MD_OFFSET_WIDTH    = 23;
    localparam int MD_ELEMENT_WIDTH   = 2;

    typedef logic [MD_OFFSET_WIDTH-1:0] offset_data_t;

    typedef struct packed {
        offset_data_t offset_x;
        offset_data_t offset_y;
        offset_data_t offset_z;
    } offset_packet_t;

    typedef enum logic [2:0] {
        PC_IDLE   = 3'd0,
        PC_STREAM = 3'd1,
        PC_DRAIN  = 3'd2,
        PC_MU     = 3'd3,
        PC_SWAP   = 3'd4
    } pos_cache_state_t;

endpackage

// File: rtl/pos_cache_bank.sv
// One position-cache bank: simple dual-port RAM, registered read port.
// Contents survive reset; only the read register is cleared.
module pos_cache_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register only moves on rd_en, so a stalled stream beat stays put.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pos_cache_pp.sv
// Ping-pong particle position cache: streams the active bank to the PE array
// and collects motion-update results into the shadow bank, swapping on MU done.
module pos_cache_pp
    import MD_pkg::*;
#(
    parameter int DEPTH         = POS_CACHE_DEPTH,
    parameter int ID_WIDTH      = $clog2(DEPTH),
    parameter int OFFSET_WIDTH  = 23,
    parameter int ELEMENT_WIDTH = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_init_wr_en,
    input  logic [ID_WIDTH-1:0]                         i_init_wr_addr,
    input  logic [3*OFFSET_WIDTH-1:0]                   i_init_data,
    input  logic [ELEMENT_WIDTH-1:0]                    i_init_element,
    input  logic                                        i_PE_start,
    output logic [ID_WIDTH+3*OFFSET_WIDTH+ELEMENT_WIDTH-1:0] o_pos_pkt,
    output logic                                        o_valid,
    input  logic                                        i_ready,
    output logic                                        o_PE_done,
    input  logic                                        i_MU_start,
    input  logic                                        i_MU_done,
    input  logic                                        i_MU_rd_en,
    input  logic [ID_WIDTH-1:0]                         i_MU_rd_addr,
    output logic [3*OFFSET_WIDTH-1:0]                   o_MU_pos,
    output logic [ELEMENT_WIDTH-1:0]                    o_MU_element,
    output logic                                        o_MU_offset_valid,
    input  logic                                        i_MU_wr_en,
    input  logic [3*OFFSET_WIDTH-1:0]                   i_MU_wr_pos,
    input  logic [ELEMENT_WIDTH-1:0]                    i_MU_wr_element,
    output logic [ID_WIDTH:0]                           o_num_particles,
    output logic                                        o_overflow,
    output logic [3:0]                                  o_debug_state
);

    localparam int POS_W = 3*OFFSET_WIDTH;
    localparam int ENT_W = POS_W + ELEMENT_WIDTH;
    localparam logic [ID_WIDTH:0] DEPTH_L = (ID_WIDTH+1)'(DEPTH);

    pos_cache_state_t state_q, state_d;

    logic              act_q;
    logic [ID_WIDTH:0] num_q, wptr_q, rd_ptr_q;
    logic [ID_WIDTH-1:0] pid_q;
    logic              valid_q, zero_done_q, mu_vld_q, ovf_q;

    logic pe_go, mu_go, issue, accept, last_accept, init_ok, mu_wr_ok, mu_wr_full;
    logic                rd_en;
    logic [ID_WIDTH-1:0] rd_addr;
    logic [1:0]                     bank_we;
    logic [1:0][ID_WIDTH-1:0]       bank_wa;
    logic [1:0][ENT_W-1:0]          bank_wd, bank_rd;
    logic [ENT_W-1:0]               act_rd;

    assign pe_go       = (state_q == PC_IDLE) && i_PE_start;
    assign mu_go       = (state_q == PC_IDLE) && i_MU_start && !i_PE_start;
    assign issue       = (state_q == PC_STREAM) && (rd_ptr_q < num_q) && (!valid_q || i_ready);
    assign accept      = valid_q && i_ready;
    assign last_accept = accept && ({1'b0, pid_q} == num_q - 1'b1);
    assign init_ok     = (state_q == PC_IDLE) && i_init_wr_en;
    assign mu_wr_full  = (state_q == PC_MU) && i_MU_wr_en && (wptr_q == DEPTH_L);
    assign mu_wr_ok    = (state_q == PC_MU) && i_MU_wr_en && (wptr_q != DEPTH_L);

    // Stream and MU reads never overlap in time, so they share one read port.
    assign rd_en   = issue || ((state_q == PC_MU) && i_MU_rd_en);
    assign rd_addr = (state_q == PC_STREAM) ? rd_ptr_q[ID_WIDTH-1:0] : i_MU_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) state_q <= PC_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_IDLE: begin
                if (i_PE_start) begin
                    if (num_q != '0) state_d = PC_STREAM;
                end else if (i_MU_start) begin
                    state_d = PC_MU;
                end
            end
            PC_STREAM: if (last_accept) state_d = PC_DRAIN;
            PC_DRAIN:  state_d = PC_IDLE;
            PC_MU:     if (i_MU_done) state_d = PC_SWAP;
            PC_SWAP:   state_d = PC_IDLE;
            default:   state_d = PC_IDLE;
        endcase
    end

    // Active bank takes init writes; the other (shadow) bank takes MU appends.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_act;
        assign is_act     = (act_q == 1'(b));
        assign bank_we[b] = is_act ? init_ok : mu_wr_ok;
        assign bank_wa[b] = is_act ? i_init_wr_addr : wptr_q[ID_WIDTH-1:0];
        assign bank_wd[b] = is_act ? {i_init_data, i_init_element}
                                   : {i_MU_wr_pos, i_MU_wr_element};

        pos_cache_bank #(
            .WIDTH (ENT_W),
            .DEPTH (DEPTH),
            .AW    (ID_WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (bank_we[b]),
            .wr_addr (bank_wa[b]),
            .wr_data (bank_wd[b]),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (bank_rd[b])
        );
    end

    assign act_rd = bank_rd[act_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q       <= 1'b0;
            num_q       <= '0;
            wptr_q      <= '0;
            rd_ptr_q    <= '0;
            pid_q       <= '0;
            valid_q     <= 1'b0;
            zero_done_q <= 1'b0;
            mu_vld_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            zero_done_q <= pe_go && (num_q == '0);
            mu_vld_q    <= (state_q == PC_MU) && i_MU_rd_en && ({1'b0, i_MU_rd_addr} < num_q);

            if (pe_go) rd_ptr_q <= '0;
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                pid_q    <= rd_ptr_q[ID_WIDTH-1:0];
            end

            if (issue)       valid_q <= 1'b1;
            else if (accept) valid_q <= 1'b0;

            if (init_ok && ({1'b0, i_init_wr_addr} >= num_q))
                num_q <= {1'b0, i_init_wr_addr} + 1'b1;

            if (mu_go)      wptr_q <= '0;
            if (mu_wr_ok)   wptr_q <= wptr_q + 1'b1;
            if (mu_wr_full) ovf_q  <= 1'b1;

            if (state_q == PC_SWAP) begin
                act_q <= ~act_q;
                num_q <= wptr_q;
            end
        end
    end

    assign o_pos_pkt         = {pid_q, act_rd};
    assign o_valid           = valid_q;
    assign o_PE_done         = (state_q == PC_DRAIN) || zero_done_q;
    assign o_MU_pos          = act_rd[ENT_W-1:ELEMENT_WIDTH];
    assign o_MU_element      = act_rd[ELEMENT_WIDTH-1:0];
    assign o_MU_offset_valid = mu_vld_q;
    assign o_num_particles   = num_q;
    assign o_overflow        = ovf_q;
    assign o_debug_state     = {1'b0, state_q};

endmodule
